// File: rtl/add_sequencer.sv
// add_sequencer: sequences reads of a run of operands from a 32 x 8 store,
// accumulates their sum, writes the result to a destination word and pulses done.
// All store-facing pins are registered so the level-sensitive store sees clean levels.
// Build option: define ADD_SEQ_SAT_EN to make the accumulator saturate at all-ones
// instead of wrapping modulo 2^DATA_W.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; busy low
//   READ  | mem_read high, address = operand pointer
//   ACC   | address held; operand added, pointer/remaining advanced
//   WRITE | mem_write high, address = destination, data = sum
//   DONE  | done pulse; back to IDLE next cycle

module add_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W:0]   i_count,
  input  logic [ADDR_W-1:0] i_dst_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_remaining;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_sum;
  logic                r_carry;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_data_in;

  logic [DATA_W:0]     w_add;
  logic                w_carry_out;
  logic [DATA_W-1:0]   w_sum_next;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic [ADDR_W:0]     w_rem_dec;

  // Adder for the accumulate step; wrap or saturate depending on build option.
  always_comb begin
    w_add       = {1'b0, r_sum} + {1'b0, i_mem_data_out};
    w_carry_out = w_add[DATA_W];
`ifdef ADD_SEQ_SAT_EN
    // Once a carry has produced all-ones, any further non-zero operand carries
    // again, so the sum stays pinned for the rest of the run.
    w_sum_next  = w_carry_out ? {DATA_W{1'b1}} : w_add[DATA_W-1:0];
`else
    w_sum_next  = w_add[DATA_W-1:0];
`endif
    w_ptr_inc   = r_ptr + ADDR_W'(1);
    w_rem_dec   = r_remaining - (ADDR_W+1)'(1);
  end

  // Sequencer FSM with registered store controls; address/data are only
  // updated on the edge where mem_write was low before the edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_remaining   <= '0;
      r_dst         <= '0;
      r_sum         <= '0;
      r_carry       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_ptr       <= i_src_addr;
            r_remaining <= i_count;
            r_dst       <= i_dst_addr;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_busy      <= 1'b1;
            if (i_count != '0) begin
              r_state       <= S_READ;
              r_mem_read    <= 1'b1;
              r_mem_address <= i_src_addr;
            end else begin
              r_state       <= S_WRITE;
              r_mem_write   <= 1'b1;
              r_mem_address <= i_dst_addr;
              r_mem_data_in <= '0;
            end
          end
        end
        S_READ: begin
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_sum       <= w_sum_next;
          r_carry     <= r_carry | w_carry_out;
          r_ptr       <= w_ptr_inc;
          r_remaining <= w_rem_dec;
          if (w_rem_dec != '0) begin
            r_state       <= S_READ;
            r_mem_address <= w_ptr_inc;
          end else begin
            r_state       <= S_WRITE;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b1;
            r_mem_address <= r_dst;
            r_mem_data_in <= w_sum_next;
          end
        end
        S_WRITE: begin
          r_state     <= S_DONE;
          r_mem_write <= 1'b0;
          r_done      <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_sum         = r_sum;
  assign o_carry       = r_carry;
  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_mem_address = r_mem_address;
  assign o_mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_add_sequencer.sv
// Testbench for add_sequencer: behavioural 32 x 8 store plus a reference model
// that sums the operand run directly from the store contents.

module tb_add_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [4:0] src_addr;
  logic [5:0] count;
  logic [4:0] dst_addr;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32];
  int         wr_total = 0;

  add_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_start        (start),
    .i_src_addr     (src_addr),
    .i_count        (count),
    .i_dst_addr     (dst_addr),
    .o_busy         (busy),
    .o_done         (done),
    .o_sum          (sum),
    .o_carry        (carry),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_mem_address  (mem_address),
    .o_mem_data_in  (mem_data_in),
    .i_mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store: registered read, write sampled at the clock edge while mem_write is high.
  always @(posedge clk) begin
    if (mem_read) mem_data_out <= mem[mem_address];
    if (mem_write) begin
      mem[mem_address] = mem_data_in;
      wr_total = wr_total + 1;
    end
  end

  // Reference: plain running total over the wrapped address run.
  task automatic model(input int src, input int cnt, output logic [7:0] s, output logic c);
    int acc;
    acc = 0;
    c   = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      acc = acc + int'(mem[(src + i) % 32]);
      if (acc > 255) begin
        c = 1'b1;
`ifdef ADD_SEQ_SAT_EN
        acc = 255;
`else
        acc = acc - 256;
`endif
      end
    end
    s = acc[7:0];
  endtask

  // One run from a negedge; checks timing, addresses, result and store contents.
  task automatic run_op(input string tag, input int src, input int cnt, input int dst,
                        input bit hammer);
    logic [7:0] exp_s;
    logic       exp_c;
    int n_busy, n_done, n_wr, done_at, wr_at, bad_rd;
    logic [7:0] got_s;
    logic       got_c;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    int last;
    model(src, cnt, exp_s, exp_c);
    last = 2 * cnt + 2;
    n_busy = 0; n_done = 0; n_wr = 0; done_at = -1; wr_at = -1; bad_rd = 0;
    got_s = 8'hxx; got_c = 1'bx; wr_addr = 'x; wr_data = 'x;
    src_addr = 5'(src);
    count    = 6'(cnt);
    dst_addr = 5'(dst);
    start    = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) begin n_done++; done_at = k; got_s = sum; got_c = carry; end
      if (mem_write) begin n_wr++; wr_at = k; wr_addr = mem_address; wr_data = mem_data_in; end
      if (k < 2 * cnt) begin
        if (mem_read !== 1'b1 || mem_address !== 5'((src + k / 2) % 32)) bad_rd++;
      end else if (mem_read !== 1'b0) bad_rd++;
      if (hammer && k < 2 * cnt + 1) begin
        start    = 1'($urandom_range(0, 1));
        src_addr = 5'($urandom);
        count    = 6'($urandom);
        dst_addr = 5'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (n_done !== 1 || done_at !== 2 * cnt + 1) begin errors++;
      $display("FAIL %s done: pulses %0d at cycle %0d, required 1 at %0d", tag, n_done, done_at, 2*cnt+1); end
    checks++; if (n_wr !== 1 || wr_at !== 2 * cnt) begin errors++;
      $display("FAIL %s write: pulses %0d at cycle %0d, required 1 at %0d", tag, n_wr, wr_at, 2*cnt); end
    checks++; if (n_busy !== 2 * cnt + 2) begin errors++;
      $display("FAIL %s busy: %0d cycles, required %0d", tag, n_busy, 2*cnt+2); end
    checks++; if (bad_rd !== 0) begin errors++;
      $display("FAIL %s read sequence: %0d bad cycles, required 0", tag, bad_rd); end
    checks++; if (got_s !== exp_s || got_c !== exp_c) begin errors++;
      $display("FAIL %s sum/carry: got %h/%b, required %h/%b", tag, got_s, got_c, exp_s, exp_c); end
    checks++; if (wr_addr !== 5'(dst) || wr_data !== exp_s) begin errors++;
      $display("FAIL %s write port: addr %0d data %h, required %0d %h", tag, wr_addr, wr_data, dst, exp_s); end
    checks++; if (mem[dst] !== exp_s) begin errors++;
      $display("FAIL %s mem[dst]: got %h, required %h", tag, mem[dst], exp_s); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0; src_addr = '0; count = '0; dst_addr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, carry, mem_read, mem_write} !== 5'b0 || sum !== 8'h00 ||
        mem_address !== 5'd0 || mem_data_in !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: busy %b done %b sum %h carry %b rd %b wr %b addr %0d din %h, required all 0",
               busy, done, sum, carry, mem_read, mem_write, mem_address, mem_data_in);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    run_op("basic4", 0, 4, 10, 1'b0);
    checks++; if (mem[10] !== 8'h0A) begin errors++;
      $display("FAIL basic4 literal: mem[10] %h, required 0a", mem[10]); end
    mem[5] = 8'h80; mem[6] = 8'h90;
    run_op("carry2", 5, 2, 7, 1'b0);
    checks++;
`ifdef ADD_SEQ_SAT_EN
    if (mem[7] !== 8'hFF || carry !== 1'b1) begin errors++;
      $display("FAIL carry2 literal: mem[7] %h carry %b, required ff 1", mem[7], carry); end
`else
    if (mem[7] !== 8'h10 || carry !== 1'b1) begin errors++;
      $display("FAIL carry2 literal: mem[7] %h carry %b, required 10 1", mem[7], carry); end
`endif
    mem[30] = 8'h01; mem[31] = 8'h02; mem[0] = 8'h04;
    run_op("wrap3", 30, 3, 12, 1'b0);
    checks++; if (mem[12] !== 8'h07) begin errors++;
      $display("FAIL wrap3 literal: mem[12] %h, required 07", mem[12]); end
    mem[3] = 8'h55;
    run_op("count0", 0, 0, 3, 1'b0);
    checks++; if (mem[3] !== 8'h00) begin errors++;
      $display("FAIL count0 literal: mem[3] %h, required 00", mem[3]); end
  endtask

  task automatic test_reset_mid_run;
    int wr_before;
    logic [7:0] dst_before;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    dst_before = mem[20];
    wr_before  = wr_total;
    src_addr = 5'd0; count = 6'd4; dst_addr = 5'd20; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== 8'h00 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-run: busy %b sum %h rd %b wr %b, required 0 00 0 0", busy, sum, mem_read, mem_write);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_total !== wr_before || mem[20] !== dst_before || done !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-run store: writes %0d mem[20] %h done %b, required %0d %h 0",
               wr_total - wr_before, mem[20], done, 0, dst_before);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 0, 4, 20, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_a", 2, 5, 25, 1'b0);
    run_op("b2b_b", 25, 3, 26, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      run_op($sformatf("rand%0d", r), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem_data_out = 8'h00;
    reset_n = 1'b0;
    start = 1'b0; src_addr = '0; count = '0; dst_addr = '0;
    test_reset;
    test_directed;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sequencer.md
# add_sequencer

Control block for the adding machine's 32 x 8 word store. On a start request it reads a run of consecutive operands from the store and accumulates their 8-bit sum, then writes the result back to a destination word and reports completion. It is the only master of the store's read/write/address/data_in pins, which it drives with registered, glitch-free levels.

## Interface
- ADDR_W, 5, store address width (32 words)
- DATA_W, 8, operand/result width
- clk  in  1  single clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- src_addr  in  ADDR_W  first operand address
- count  in  ADDR_W+1  number of operands, 0..63
- dst_addr  in  ADDR_W  result address
- busy  out  1  high from start acceptance until DONE ends
- done  out  1  one-cycle pulse, result written
- sum  out  DATA_W  accumulator; valid when done, held until next start
- carry  out  1  sticky: any carry out of bit DATA_W-1 during the run
- mem_read  out  1  to store read
- mem_write  out  1  to store write
- mem_address  out  ADDR_W  to store address
- mem_data_in  out  DATA_W  to store data_in
- mem_data_out  in  DATA_W  from store data_out

## Operation
- States: IDLE, READ, ACC, WRITE, DONE.
- IDLE: busy=0. start=1 latches src_addr -> ptr, count -> remaining, dst_addr; clears sum and carry; next READ if count!=0, else WRITE.
- READ: mem_read=1, mem_address=ptr. Next ACC.
- ACC: mem_read=1, mem_address=ptr held; sum <= sum + mem_data_out (modulo 2^DATA_W); carry |= carry-out; ptr <= ptr+1 modulo 32 (31 wraps to 0); remaining--. Next READ if remaining after decrement !=0, else WRITE.
- WRITE: mem_write=1, mem_address=dst, mem_data_in=sum, mem_read=0. Next DONE.
- DONE: done=1, mem_write=0. Next IDLE.
- count > 32 is legal: addresses wrap and words are re-read.
- start while busy is ignored; no queuing.
- All mem_* outputs are registered; mem_address and mem_data_in change only while mem_write=0, because the store writes on level.
- Reset (reset_n low, any state, asynchronous): state IDLE; busy, done, mem_read, mem_write = 0; mem_address, mem_data_in, sum = 0; carry = 0. An interrupted run never asserts mem_write.

## Timing
- Start accepted at edge E0 (start=1 in IDLE). READ occupies E0..E1, ACC E1..E2; N operands take 2N cycles.
- WRITE is cycle 2N after E0; done=1 in cycle 2N+1; busy falls with return to IDLE at edge E(2N+2).
- count=0: WRITE in cycle 0, done in cycle 1, writes 0.
- mem_write is high for exactly one cycle per run.
- A new start is accepted on the first IDLE cycle after done.

## Configuration
- ADD_SEQ_SAT_EN defined: ACC saturates; on carry-out, sum becomes all-ones and stays there for the rest of the run. carry is set as normal.
- Not defined: sum wraps modulo 2^DATA_W.

## Test plan
- mem[0..3]=01,02,03,04; src=0, count=4, dst=10 -> mem[10]=0x0A, sum=0x0A, carry=0; done in cycle 9, busy for 10 cycles.
- mem[5]=0x80, mem[6]=0x90; src=5, count=2, dst=7 -> mem[7]=0x10, carry=1 without the macro; mem[7]=0xFF, carry=1 with ADD_SEQ_SAT_EN.
- mem[30]=1, mem[31]=2, mem[0]=4; src=30, count=3 -> addresses 30, 31, 0 are read; mem[dst]=0x07.
- count=0, dst=3, mem[3]=0x55 -> mem[3]=0x00; done in cycle 1.
- reset_n low during the ACC cycle of operand 2 of a 4-operand run -> busy=0, sum=0 immediately, mem_write never high, mem[dst] unchanged. The next start runs normally.
- start pulsed again while busy -> ignored; exactly one mem_write and one done pulse per accepted start.
